// File: rtl/debug_dump_sequencer_pkg.sv
// Shared definitions for the debug dump sequencer: FSM states, default header
// bytes and the expected frame length.
package dbg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_DM_RD,
        S_DM_TX,
        S_RB_RD,
        S_RB_TX,
        S_CLK,
        S_CSUM,
        S_FIN
    } state_t;

    localparam logic [7:0] HDR_FULL_DEFAULT  = 8'hA5;
    localparam logic [7:0] HDR_SHORT_DEFAULT = 8'h5A;

    function automatic int unsigned frame_bytes(input int unsigned dw,
                                                input int unsigned dm,
                                                input int unsigned rb,
                                                input logic        short_frame);
        return short_frame ? 2 + 2 * (dw / 8) : 2 + (dw / 8) * (2 + dm + rb);
    endfunction

endpackage

// File: rtl/debug_dump_sequencer_word_serializer.sv
// Sends one word (or a single byte) LSB first over a tx_start/tx_done byte
// handshake; o_word_done is high in the cycle the last byte's tx_done arrives.
module word_serializer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_single,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_tx_done,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_word_done,
    output logic                  o_active
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_last;
    logic                  r_active;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  w_last_done;

    assign w_last_done = r_active && i_tx_done && (r_idx == r_last);
    assign o_word_done = w_last_done;
    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_active    = r_active;

    // A load may coincide with the previous word's final tx_done; it takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_idx      <= '0;
            r_last     <= '0;
            r_active   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (i_load) begin
                r_tx_data  <= i_word[7:0];
                r_shift    <= i_word >> 8;
                r_idx      <= '0;
                r_last     <= i_single ? '0 : IW'(NBYTES - 1);
                r_active   <= 1'b1;
                r_tx_start <= 1'b1;
            end else if (r_active && i_tx_done) begin
                if (r_idx == r_last) begin
                    r_active <= 1'b0;
                end else begin
                    r_idx      <= r_idx + 1'b1;
                    r_tx_data  <= r_shift[7:0];
                    r_shift    <= r_shift >> 8;
                    r_tx_start <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams a framed debug snapshot (header, PC, DM, RB, clock count, XOR checksum)
// byte-wise to a UART transmitter on a start request.
module debug_dump_sequencer
    import dbg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DM_DEPTH   = 1024,
    parameter int unsigned RB_REGS    = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter logic [7:0]  HDR_FULL   = HDR_FULL_DEFAULT,
    parameter logic [7:0]  HDR_SHORT  = HDR_SHORT_DEFAULT,
    localparam int unsigned DAW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1,
    localparam int unsigned RAW = (RB_REGS > 1) ? $clog2(RB_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  short_mode,
    input  logic [DATA_WIDTH-1:0] current_pc,
    input  logic [DATA_WIDTH-1:0] clock_count,
    output logic [DAW-1:0]        dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_data,
    output logic [RAW-1:0]        rb_addr,
    input  logic [DATA_WIDTH-1:0] rb_data,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LW = $clog2(RD_LAT + 1) + 1;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_clk;
    logic                  r_short;
    logic [7:0]            r_csum;
    logic [DAW-1:0]        r_dm_addr;
    logic [RAW-1:0]        r_rb_addr;
    logic [LW-1:0]         r_lat;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_load;
    logic                  w_single;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_ws_done;
    logic                  w_ws_active;
    logic                  w_dm_last;
    logic                  w_rb_last;

    assign w_dm_last = (r_dm_addr == DAW'(DM_DEPTH - 1));
    assign w_rb_last = (r_rb_addr == RAW'(RB_REGS - 1));

    // Next word is handed over on the same edge as the previous word's last tx_done.
    always_comb begin
        w_load   = 1'b0;
        w_single = 1'b0;
        w_word   = '0;
        case (r_state)
            S_IDLE: if (start) begin
                w_load   = 1'b1;
                w_single = 1'b1;
                w_word   = DATA_WIDTH'(short_mode ? HDR_SHORT : HDR_FULL);
            end
            S_HDR: if (w_ws_done) begin
                w_load = 1'b1;
                w_word = r_pc;
            end
            S_PC: if (w_ws_done && r_short) begin
                w_load = 1'b1;
                w_word = r_clk;
            end
            S_DM_RD: if (r_lat == LW'(RD_LAT)) begin
                w_load = 1'b1;
                w_word = dm_data;
            end
            S_RB_RD: if (r_lat == LW'(RD_LAT)) begin
                w_load = 1'b1;
                w_word = rb_data;
            end
            S_RB_TX: if (w_ws_done && w_rb_last) begin
                w_load = 1'b1;
                w_word = r_clk;
            end
            S_CLK: if (w_ws_done) begin
                w_load   = 1'b1;
                w_single = 1'b1;
                w_word   = DATA_WIDTH'(r_csum);
            end
            default: ;
        endcase
    end

    word_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_single    (w_single),
        .i_word      (w_word),
        .i_tx_done   (tx_done),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_word_done (w_ws_done),
        .o_active    (w_ws_active)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_clk     <= '0;
            r_short   <= 1'b0;
            r_csum    <= '0;
            r_dm_addr <= '0;
            r_rb_addr <= '0;
            r_lat     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (tx_start) r_csum <= r_csum ^ tx_data;
            case (r_state)
                S_IDLE: if (start) begin
                    r_busy  <= 1'b1;
                    r_pc    <= current_pc;
                    r_clk   <= clock_count;
                    r_short <= short_mode;
                    r_csum  <= '0;
                    r_state <= S_HDR;
                end
                S_HDR: if (w_ws_done) r_state <= S_PC;
                S_PC: if (w_ws_done) begin
                    r_lat   <= '0;
                    r_state <= r_short ? S_CLK : S_DM_RD;
                end
                S_DM_RD: begin
                    if (r_lat == LW'(RD_LAT)) r_state <= S_DM_TX;
                    else r_lat <= r_lat + 1'b1;
                end
                S_DM_TX: if (w_ws_done) begin
                    r_lat <= '0;
                    if (w_dm_last) begin
                        r_dm_addr <= '0;
                        r_state   <= S_RB_RD;
                    end else begin
                        r_dm_addr <= r_dm_addr + 1'b1;
                        r_state   <= S_DM_RD;
                    end
                end
                S_RB_RD: begin
                    if (r_lat == LW'(RD_LAT)) r_state <= S_RB_TX;
                    else r_lat <= r_lat + 1'b1;
                end
                S_RB_TX: if (w_ws_done) begin
                    r_lat <= '0;
                    if (w_rb_last) begin
                        r_rb_addr <= '0;
                        r_state   <= S_CLK;
                    end else begin
                        r_rb_addr <= r_rb_addr + 1'b1;
                        r_state   <= S_RB_RD;
                    end
                end
                S_CLK: if (w_ws_done) r_state <= S_CSUM;
                S_CSUM: if (w_ws_done) begin
                    r_done  <= 1'b1;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dm_addr = r_dm_addr;
    assign rb_addr = r_rb_addr;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
